arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- Parametrised N-channel multiplexer; the next step up from the combinational select-driven mux.
- An internal arbiter, not an external select, chooses among valid/ready input channels.
- The winner is registered into a single-entry output stage carrying a valid/ready handshake.
- Used where several producers (e.g. writeback sources, bus masters) share one downstream consumer.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 4, number of input channels; legal range 2..16, need not be a power of two.
- MODE, ARB_RR, arbitration mode from mux_pkg: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
- SELW, $clog2(NCH), localparam, width of the channel index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst_n=0.
  - Reset asserted mid-transfer drops the held word. No partial state survives.
- Load condition: load = !out_valid || out_ready.
  - The output register accepts a new word when empty, or when it is drained in the same cycle.
  - This gives full throughput of one word per cycle.
- Grant (combinational):
  - ARB_FIXED: g = lowest i with in_valid[i]=1.
  - ARB_RR: g = first i with in_valid[i]=1, searching ptr, ptr+1, … NCH-1, 0, … ptr-1 (modulo NCH).
- in_ready[g] = load && |in_valid. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready. No combinational path exists from in_data.
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge.
  - Next cycle: out_data=in_data[g], out_ch=g, out_valid=1.
  - Latency is exactly 1 cycle, input handshake to out_valid.
- Pointer update (ARB_RR only):
  - On a transfer, ptr <= (g==NCH-1) ? 0 : g+1. Wrap-around is explicit for non-power-of-2 NCH.
  - No transfer leaves ptr unchanged.
  - ARB_FIXED ignores ptr; it stays 0.
- Drain with no request (out_valid && out_ready, no in_valid): out_valid <= 0. out_data and out_ch hold their last value.
- Stall (out_valid && !out_ready):
  - out_valid, out_data and out_ch are held stable.
  - All in_ready=0 and ptr is unchanged.
- Simultaneous drain and load: the new word replaces the old one in the same edge, with no bubble.
- Requester rules:
  - A requester must keep in_valid and in_data stable until its handshake completes.
  - The block does not latch requests; a deasserted in_valid simply drops out of arbitration.
- Fairness: under ARB_RR with all NCH channels continuously valid and out_ready=1, each channel is granted once every NCH cycles.
- Out-of-range index: out_ch never exceeds NCH-1. Indices NCH..2^SELW-1 never occur.

Decomposition:
- mux_pkg holds:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e
  - constant MAX_NCH=16
- Sub-module rr_arbiter: combinational grant one-hot plus index from (req, ptr, mode), parameterised by NCH.
- arb_mux keeps the output register, the load logic and ptr.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, in_ready=0, out_data=0. Release -> first word arrives 1 cycle after the first handshake.
- RR, NCH=4, all valid, out_ready=1, in_data[i]=32'hA0+i for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, out_data matching. ptr wraps 3->0.
- RR skip: in_valid=4'b1010, ptr=0 -> grant ch1 then ch3 then ch1. in_ready[0] and in_ready[2] never assert.
- Stall: out_valid=1, out_data=32'hDEAD, out_ready=0 for 5 cycles with requests pending -> out_data held, in_ready=0, ptr unchanged. Raising out_ready -> next word loads in the same edge (no bubble).
- ARB_FIXED, in_valid=4'b1100 held for 3 cycles -> ch2 granted every cycle, ch3 starved. in_valid=4'b1000 -> ch3 granted.
- NCH=3, RR, all valid -> out_ch 0,1,2,0. Value 3 never appears. Async reset asserted mid-stream -> out_valid falls immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and limits for the arbitrated channel mux.
// Arbitration modes and the wrap-around pointer helper.
package mux_pkg;

  typedef enum logic {
    ARB_RR,
    ARB_FIXED
  } arb_mode_e;

  localparam int MAX_NCH = 16;

  // Next round-robin start position; explicit wrap for non-pow2 channel counts.
  function automatic int next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection among requesting channels.
// Searches from ptr (round-robin) or from 0 (fixed priority).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  arb_mode_e       mode,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  always_comb begin
    int start;
    int c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    start = (mode == ARB_FIXED) ? 0 : int'(ptr);
    for (int k = 0; k < NCH; k++) begin
      c = start + k;
      if (c >= NCH) c = c - NCH;
      if (!found && req[c]) begin
        found  = 1'b1;
        idx    = SELW'(c);
        gnt[c] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux with a registered valid/ready output.
// Output register refills in the same edge it drains: one word per cycle.
module arb_mux
  import mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        NCH   = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch
);

  logic [NCH-1:0]  gnt;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] ptr;
  logic            any;
  logic            load;
  logic            xfer;

  rr_arbiter #(
    .NCH(NCH)
  ) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .mode(MODE),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign load = !out_valid || out_ready;
  assign xfer = load && any;

  // Reset gating keeps producers from seeing an accept while held in reset.
  assign in_ready = (xfer && rst_n) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_ch    <= gidx;
        if (MODE == ARB_RR)
          ptr <= SELW'(next_ptr(int'(gidx), NCH));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: RR x4, FIXED x4, RR x3.
// Stimulus pushes expected {ch,data}; monitors pop on output handshakes.
module tb_arb_mux;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT A: round-robin, 4 channels
  logic         ra;
  logic [3:0]   va, rdya;
  logic [127:0] da;
  logic         ova, ora;
  logic [31:0]  oda;
  logic [1:0]   oca;

  // DUT B: fixed priority, 4 channels
  logic         rb;
  logic [3:0]   vb, rdyb;
  logic [127:0] db;
  logic         ovb, orb;
  logic [31:0]  odb;
  logic [1:0]   ocb;

  // DUT C: round-robin, 3 channels
  logic         rc;
  logic [2:0]   vc, rdyc;
  logic [95:0]  dc;
  logic         ovc, orc;
  logic [31:0]  odc;
  logic [1:0]   occ;

  logic [35:0] qa[$];
  logic [35:0] qb[$];
  logic [35:0] qc[$];

  arb_mux #(.WIDTH(32), .NCH(4), .MODE(ARB_RR)) u_a (
    .clk(clk), .rst_n(ra), .in_valid(va), .in_data(da),
    .in_ready(rdya), .out_valid(ova), .out_ready(ora),
    .out_data(oda), .out_ch(oca)
  );

  arb_mux #(.WIDTH(32), .NCH(4), .MODE(ARB_FIXED)) u_b (
    .clk(clk), .rst_n(rb), .in_valid(vb), .in_data(db),
    .in_ready(rdyb), .out_valid(ovb), .out_ready(orb),
    .out_data(odb), .out_ch(ocb)
  );

  arb_mux #(.WIDTH(32), .NCH(3), .MODE(ARB_RR)) u_c (
    .clk(clk), .rst_n(rc), .in_valid(vc), .in_data(dc),
    .in_ready(rdyc), .out_valid(ovc), .out_ready(orc),
    .out_data(odc), .out_ch(occ)
  );

  always @(negedge clk) begin
    chk("a_onehot", 64'($countones(rdya) <= 1), 64'd1);
    if (ova && ora) begin
      if (qa.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL a_extra: got ch %0d data %0h want none", oca, oda);
      end else begin
        chk("a_word", {28'd0, 2'b00, oca, oda}, {28'd0, qa.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (ovb && orb) begin
      if (qb.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL b_extra: got ch %0d data %0h want none", ocb, odb);
      end else begin
        chk("b_word", {28'd0, 2'b00, ocb, odb}, {28'd0, qb.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (ovc) chk("c_range", 64'(occ <= 2'd2), 64'd1);
    if (ovc && orc) begin
      if (qc.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL c_extra: got ch %0d data %0h want none", occ, odc);
      end else begin
        chk("c_word", {28'd0, 2'b00, occ, odc}, {28'd0, qc.pop_front()});
      end
    end
  end

  initial begin
    ra  = 1'b0; rb  = 1'b0; rc  = 1'b0;
    va  = 4'b1111;
    da  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    ora = 1'b1;
    vb  = '0; db = '0; orb = 1'b1;
    vc  = '0; dc = '0; orc = 1'b1;

    // reset held with all requests asserted
    tick();
    tick();
    chk("rst_ova", 64'(ova), 64'd0);
    chk("rst_rdya", 64'(rdya), 64'd0);
    chk("rst_oda", 64'(oda), 64'd0);
    chk("rst_oca", 64'(oca), 64'd0);

    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    #1;
    chk("a_rdy_first", 64'(rdya), 64'b0001);
    chk("a_lat0", 64'(ova), 64'd0);

    // RR all valid: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      qa.push_back({4'(i % 4), 32'(32'hA0 + i % 4)});
    tick();
    chk("a_lat1", {62'd0, ova, 1'b0} | 64'(oca), {62'd0, 2'b10});
    repeat (7) tick();

    // RR skip with ptr back at 0: ch1, ch3, ch1
    va = 4'b1010;
    qa.push_back({4'd1, 32'hA1});
    qa.push_back({4'd3, 32'hA3});
    qa.push_back({4'd1, 32'hA1});
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("a_skip_rdy", 64'(rdya & 4'b0101), 64'd0);
      tick();
    end
    va = 4'b0000;
    tick();
    tick();

    // stall: hold DEAD with requests pending
    ora = 1'b0;
    va  = 4'b0001;
    da  = {32'hB3, 32'hB2, 32'hB1, 32'hDEAD};
    qa.push_back({4'd0, 32'hDEAD});
    tick();
    va = 4'b1110;
    qa.push_back({4'd1, 32'hB1});
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_data", 64'(oda), 64'hDEAD);
      chk("stall_valid", 64'(ova), 64'd1);
      chk("stall_rdy", 64'(rdya), 64'd0);
      tick();
    end
    ora = 1'b1;
    #1;
    chk("a_unstall_rdy", 64'(rdya), 64'b0010);
    tick();
    chk("a_nobubble", {61'd0, ova, oca}, {61'd0, 1'b1, 2'd1});
    va = 4'b0000;
    tick();
    tick();

    // FIXED: ch2 wins three times, then ch3 alone
    vb = 4'b1100;
    db = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    for (int i = 0; i < 3; i++) qb.push_back({4'd2, 32'hC2});
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_rdy_ch2", 64'(rdyb), 64'b0100);
      tick();
    end
    vb = 4'b1000;
    qb.push_back({4'd3, 32'hC3});
    #1;
    chk("b_rdy_ch3", 64'(rdyb), 64'b1000);
    tick();
    vb = 4'b0000;
    tick();
    tick();

    // NCH=3 RR: 0,1,2,0 then async reset mid-cycle
    vc = 3'b111;
    dc = {32'hD2, 32'hD1, 32'hD0};
    qc.push_back({4'd0, 32'hD0});
    qc.push_back({4'd1, 32'hD1});
    qc.push_back({4'd2, 32'hD2});
    tick();
    tick();
    tick();
    tick();
    chk("c_wrap", {28'd0, 2'b00, occ, odc}, {28'd0, 4'd0, 32'hD0});
    chk("c_wrap_valid", 64'(ovc), 64'd1);
    #1;
    rc = 1'b0;
    #1;
    chk("c_async_ov", 64'(ovc), 64'd0);
    chk("c_async_rdy", 64'(rdyc), 64'd0);
    chk("c_async_data", 64'(odc), 64'd0);
    vc = 3'b000;
    tick();
    rc = 1'b1;
    tick();
    tick();

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    chk("qc_empty", 64'(qc.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
